// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN input loader.
// Holds the loader FSM encoding and frame/ASCII constants.
package snn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_START,
    S_WAIT_DONE,
    S_SEND
  } state_t;

  localparam int          NUM_PIXELS = 784;
  localparam logic [7:0]  ASCII_ZERO = 8'h30;

endpackage

// File: rtl/snn_input_loader.sv
// Unpacks received image bytes into a 1-bit pixel RAM, starts the
// inference core, and returns the classified digit as ASCII.
module snn_input_loader
  import snn_pkg::*;
#(
  parameter int NUM_BYTES = 98
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic       ram_data,
  output logic       snn_start,
  input  logic       snn_done,
  input  logic [3:0] snn_digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       ovf
);

  localparam int BCW = $clog2(NUM_BYTES);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);

  state_t           r_state;
  logic [BCW-1:0]   r_byte_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_pend;
  logic             r_pend_full;
  logic [3:0]       r_digit;
  logic             r_ovf;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;

  logic             w_unpack;
  logic [9:0]       w_addr;

  assign w_unpack = (r_state == S_UNPACK);
  assign w_addr   = 10'({r_byte_cnt, r_bit_cnt});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_digit     <= '0;
      r_ovf       <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_rdy) begin
            r_shift <= rx_data;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_byte_cnt == LAST_BYTE) begin
              // Frame complete; anything still queued is lost.
              r_byte_cnt  <= '0;
              r_pend_full <= 1'b0;
              r_state     <= S_START;
              if (rx_rdy || r_pend_full) r_ovf <= 1'b1;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              if (r_pend_full) begin
                r_shift <= r_pend;
                if (rx_rdy) r_pend <= rx_data;
                else        r_pend_full <= 1'b0;
              end else if (rx_rdy) begin
                r_shift <= rx_data;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end else if (rx_rdy) begin
            if (r_pend_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_pend      <= rx_data;
              r_pend_full <= 1'b1;
            end
          end
        end
        S_START: begin
          if (rx_rdy) r_ovf <= 1'b1;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (rx_rdy) r_ovf <= 1'b1;
          if (snn_done) begin
            r_digit <= snn_digit;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (rx_rdy) r_ovf <= 1'b1;
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= ASCII_ZERO + {4'd0, r_digit};
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_we    = w_unpack;
  assign ram_addr  = w_unpack ? w_addr : 10'd0;
  assign ram_data  = w_unpack & r_shift[0];
  assign snn_start = (r_state == S_START);
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_snn_input_loader.sv
// Scoreboard bench for snn_input_loader: expected RAM writes are
// queued at stimulus time and popped as the DUT writes.
module tb_snn_input_loader;

  localparam int NB   = 98;
  localparam int NPIX = NB * 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = '0;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_data;
  logic       snn_start;
  logic       snn_done = 1'b0;
  logic [3:0] snn_digit = '0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       ovf;

  snn_input_loader #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .snn_start (snn_start),
    .snn_done  (snn_done),
    .snn_digit (snn_digit),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int tx_cnt = 0;
  int tx_cyc = 0;
  logic [7:0] tx_val = '0;
  logic start_after_wr = 1'b0;
  logic prev_we = 1'b0;
  logic [10:0] sb[$];
  int exp_addr = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ram_we) begin
      logic [10:0] e;
      wr_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL ram_write unexpected addr=%0d data=%0d required=none",
                 ram_addr, ram_data);
      end else begin
        e = sb.pop_front();
        if ({ram_addr, ram_data} !== e) begin
          errors++;
          $display("FAIL ram_write addr=%0d data=%0d required addr=%0d data=%0d",
                   ram_addr, ram_data, e[10:1], e[0]);
        end
      end
      checks++;
      if (ram_addr > 10'(NPIX - 1)) begin
        errors++;
        $display("FAIL ram_addr_range addr=%0d required<=%0d", ram_addr, NPIX - 1);
      end
    end
    if (snn_start) begin
      start_cnt++;
      start_after_wr = prev_we;
    end
    if (tx_start) begin
      tx_cnt++;
      tx_val = tx_data;
      tx_cyc = cyc;
    end
    prev_we = ram_we;
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      sb.push_back({10'(exp_addr), b[i]});
      exp_addr++;
    end
    if (exp_addr >= NPIX) exp_addr = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1;
    rx_rdy = 1'b1;
    rx_data = b;
    push_byte(b);
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    rx_rdy = 1'b0;
    snn_done = 1'b0;
    sb.delete();
    exp_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_start(input int s0, output logic ok);
    int n = 0;
    while (start_cnt == s0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    ok = (start_cnt != s0);
  endtask

  task automatic wait_tx(input int t0, output logic ok);
    int n = 0;
    while (tx_cnt == t0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    ok = (tx_cnt != t0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_we, ram_addr, ram_data, snn_start, tx_start, tx_data, ovf} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got we=%0d addr=%0d d=%0d st=%0d tx=%0d txd=%0h ovf=%0d required all 0",
               ram_we, ram_addr, ram_data, snn_start, tx_start, tx_data, ovf);
    end
    #1 rst = 1'b0;
    send_byte(8'h81, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    exp_addr = 0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 10'd0) begin
      errors++;
      $display("FAIL async_reset got we=%0d addr=%0d required we=0 addr=0",
               ram_we, ram_addr);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [19:0] we_seen;
    logic [19:0] we_exp;
    do_reset();
    we_exp = 20'h1FFFE;
    fork
      begin
        @(posedge clk);
        #1;
        rx_rdy = 1'b1;
        rx_data = 8'h3C;
        push_byte(8'h3C);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        @(posedge clk);
        #1;
        rx_rdy = 1'b1;
        rx_data = 8'hC3;
        push_byte(8'hC3);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          we_seen[i] = ram_we;
        end
      end
    join
    checks++;
    if (we_seen !== we_exp) begin
      errors++;
      $display("FAIL b2b_we_pattern got %05h required %05h", we_seen, we_exp);
    end
    checks++;
    if (ovf !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_ovf ovf=%0d left=%0d required ovf=0 left=0", ovf, sb.size());
    end
  endtask

  task automatic test_overrun();
    int w0;
    do_reset();
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    rx_rdy = 1'b1;
    rx_data = 8'h0F;
    push_byte(8'h0F);
    @(posedge clk);
    #1;
    rx_data = 8'hF0;
    push_byte(8'hF0);
    @(posedge clk);
    #1;
    rx_data = 8'hFF;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    repeat (25) @(posedge clk);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL overrun_ovf got %0d required 1", ovf);
    end
    checks++;
    if (wr_cnt - w0 != 16 || sb.size() != 0) begin
      errors++;
      $display("FAIL overrun_writes got %0d left=%0d required 16 left=0",
               wr_cnt - w0, sb.size());
    end
  endtask

  task automatic test_full_frame();
    int s0;
    int t0;
    int fall;
    logic ok;
    do_reset();
    tx_busy = 1'b1;
    s0 = start_cnt;
    for (int i = 0; i < NB; i++) send_byte(8'hA5, 18);
    wait_start(s0, ok);
    checks++;
    if (!ok || start_cnt != s0 + 1 || start_after_wr !== 1'b1) begin
      errors++;
      $display("FAIL frame_start got starts=%0d after_wr=%0d required 1 and 1",
               start_cnt - s0, start_after_wr);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL frame_writes left=%0d required 0", sb.size());
    end
    #1;
    snn_done = 1'b1;
    snn_digit = 4'd7;
    @(posedge clk);
    #1;
    snn_done = 1'b0;
    t0 = tx_cnt;
    repeat (10) @(posedge clk);
    checks++;
    if (tx_cnt != t0) begin
      errors++;
      $display("FAIL tx_while_busy got %0d pulses required 0", tx_cnt - t0);
    end
    #1;
    tx_busy = 1'b0;
    fall = cyc;
    wait_tx(t0, ok);
    repeat (5) @(posedge clk);
    checks++;
    if (!ok || tx_cnt != t0 + 1 || tx_cyc < fall) begin
      errors++;
      $display("FAIL tx_pulse got %0d pulses at %0d required 1 after %0d",
               tx_cnt - t0, tx_cyc, fall);
    end
    checks++;
    if (tx_val !== 8'h37) begin
      errors++;
      $display("FAIL tx_data got %02h required 37", tx_val);
    end
    checks++;
    if (ovf !== 1'b0 || start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL frame_ovf ovf=%0d starts=%0d required 0 and 1",
               ovf, start_cnt - s0);
    end
    send_byte(8'h01, 10);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL next_frame_addr0 left=%0d required 0", sb.size());
    end
  endtask

  task automatic test_reset_midframe();
    int s0;
    logic ok;
    do_reset();
    s0 = start_cnt;
    for (int i = 0; i < 50; i++) send_byte(8'(i * 3 + 1), 9);
    repeat (5) @(posedge clk);
    do_reset();
    checks++;
    if (start_cnt != s0) begin
      errors++;
      $display("FAIL partial_start got %0d required 0", start_cnt - s0);
    end
    for (int i = 0; i < NB; i++) send_byte(8'(i * 7 + 2), 9);
    wait_start(s0, ok);
    repeat (3) @(posedge clk);
    checks++;
    if (!ok || start_cnt != s0 + 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL midreset_start got %0d left=%0d required 1 left=0",
               start_cnt - s0, sb.size());
    end
    #1;
    snn_done = 1'b1;
    snn_digit = 4'd0;
    @(posedge clk);
    #1 snn_done = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_wait_done_ovf();
    int s0;
    int t0;
    int w0;
    logic ok;
    do_reset();
    tx_busy = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < NB; i++) send_byte(8'(i * 37), 9);
    wait_start(s0, ok);
    w0 = wr_cnt;
    #1;
    rx_rdy = 1'b1;
    rx_data = 8'hFF;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (!ok || ovf !== 1'b1 || wr_cnt != w0) begin
      errors++;
      $display("FAIL wait_rx ovf=%0d writes=%0d required ovf=1 writes=0",
               ovf, wr_cnt - w0);
    end
    t0 = tx_cnt;
    #1;
    snn_done = 1'b1;
    snn_digit = 4'd3;
    @(posedge clk);
    #1;
    snn_done = 1'b0;
    wait_tx(t0, ok);
    checks++;
    if (!ok || tx_val !== 8'h33) begin
      errors++;
      $display("FAIL wait_tx got %02h required 33", tx_val);
    end
    repeat (3) @(posedge clk);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %0d required 1", ovf);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_overrun();
    test_full_frame();
    test_reset_midframe();
    test_wait_done_ovf();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
